alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer that executes one register-to-register ALU command at a time over the team's single-read-port register file and 2-bit-opcode ALU. It accepts a command (op, rs1, rs2, rd) on a valid/ready handshake and performs, in order, two operand reads, one ALU evaluation and one write-back. It then pulses done with the zero flag. It sits between the instruction/command source and the register file and ALU, and is their only master.

## Interface
- ADD_BITS, 2, register address width; the register file holds 2^ADD_BITS entries
- DATA_W, 32, datapath width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  ALU operation: 0 ADD, 1 SUB, 2 MUL, 3 signed SLT
- cmd_rs1 / cmd_rs2 / cmd_rd  in  ADD_BITS each  source and destination registers
- rf_ra  out  ADD_BITS  register file read address; read is combinational
- rf_rd  in  DATA_W  register file read data
- rf_wa  out  ADD_BITS  write address
- rf_wd  out  DATA_W  write data
- rf_we  out  1  write enable
- alu_op1 / alu_op2  out  DATA_W  ALU operands
- alu_oper  out  2  ALU operation select
- alu_result  in  DATA_W  ALU result; combinational
- alu_zero  in  1  ALU zero flag
- done  out  1  one-cycle pulse: the write-back happens this cycle
- done_zero  out  1  zero flag of the completed command, valid while done=1
- busy  out  1  high in every state except IDLE

## Operation
- The FSM has five states: IDLE, RD1, RD2, EXEC, WB. Each state lasts exactly one cycle, except IDLE.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid & cmd_ready, latch op, rs1, rs2 and rd, then go to RD1.
  - Otherwise stay in IDLE.
- RD1: rf_ra=rs1. Capture rf_rd into op1_q, then go to RD2.
- RD2: rf_ra=rs2. Capture rf_rd into op2_q, then go to EXEC.
- EXEC:
  - alu_op1=op1_q, alu_op2=op2_q, alu_oper=op_q. These outputs are driven from the latched registers in every state.
  - Capture alu_result into res_q and alu_zero into zero_q, then go to WB.
- WB: rf_we=1, rf_wa=rd_q, rf_wd=res_q, done=1, done_zero=zero_q. Then go to IDLE.
- rf_ra is 0 outside RD1/RD2. rf_wa and rf_wd are always driven from rd_q and res_q. rf_we is high only in WB.
- Command inputs are sampled only at acceptance. Changes while busy are ignored.
- rs1==rs2 and rd==rs1/rs2 are legal. The write happens after both reads, so the sources hold their old values.
- MUL keeps the low DATA_W bits. SLT yields 1 or 0. Arithmetic belongs to the ALU; the sequencer only transports values.

## Timing
- Command accepted at the edge ending cycle 0; done and rf_we are high in cycle 4; cmd_ready is high again in cycle 5. Maximum throughput is one command per 5 cycles.
- cmd_ready = (state==IDLE), combinational from state. There is no back-to-back acceptance in WB.
- Reset values:
  - state IDLE.
  - op_q, rs1_q, rs2_q, rd_q, op1_q, op2_q, res_q and zero_q all 0.
  - Outputs therefore reset to: rf_we=0, done=0, busy=0, cmd_ready=1, rf_ra=0, rf_wa=0, rf_wd=0, alu_op1=alu_op2=0, alu_oper=0, done_zero=0.
- Reset has priority over every transition. cmd_valid sampled in a cycle where reset=1 is not accepted.
- Reset mid-command (any of RD1..WB): return to IDLE on that edge. No later write occurs. A reset in the WB cycle does not suppress the write already asserted combinationally in that cycle.

## Structure
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, RD1, RD2, EXEC, WB);
  - the ALU opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_SLT=3;
  - the opcode type, 2 bits wide.
  - The ALU and other command producers share the opcode constants.
- Single module. The FSM and the operand/result latches are small enough to stay inline, so no sub-module is needed.

## Test plan
The bench instantiates a behavioural 4-entry register file and the ALU.
- ADD: preload r1=5 and r2=7; op=0, rs1=1, rs2=2, rd=3.
  - done in cycle 4 with rf_we=1, rf_wa=3, rf_wd=12, done_zero=0.
  - r3 reads 12 afterwards.
- SUB to zero: r1=9; op=1, rs1=1, rs2=1, rd=0 -> rf_wd=0, done_zero=1.
- SLT signed: r1=0xFFFFFFFF, r2=1; op=3, rd=2 -> r2=1.
  - Then op=3, rs1=2, rs2=1 (1 < -1 false) -> result 0, done_zero=1.
- Overlap/ignore: hold cmd_valid=1 continuously with changing fields.
  - Commands are accepted only in cycles 0, 5, 10.
  - cmd_ready=0 during cycles 1-4.
  - Only the latched fields are executed.
- Destination-is-source: r1=3; op=2, rs1=1, rs2=1, rd=1 -> r1=9, using the operands read before the write.
- Reset mid-operation: assert reset in EXEC.
  - Next cycle: state IDLE, busy=0, cmd_ready=1.
  - No rf_we pulse; the destination register is unchanged.
  - A following ADD completes normally in 5 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer and its command producers.
// Holds the sequencer state encoding and the 2-bit ALU opcode constants.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_e;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'd0;
  localparam alu_op_t OP_SUB = 2'd1;
  localparam alu_op_t OP_MUL = 2'd2;
  localparam alu_op_t OP_SLT = 2'd3;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Five-state sequencer: read rs1, read rs2, evaluate, write back rd.
// Sole master of the single-read-port register file and the ALU.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int ADD_BITS = 2,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  alu_op_t             cmd_op,
  input  logic [ADD_BITS-1:0] cmd_rs1,
  input  logic [ADD_BITS-1:0] cmd_rs2,
  input  logic [ADD_BITS-1:0] cmd_rd,
  output logic [ADD_BITS-1:0] rf_ra,
  input  logic [DATA_W-1:0]   rf_rd,
  output logic [ADD_BITS-1:0] rf_wa,
  output logic [DATA_W-1:0]   rf_wd,
  output logic                rf_we,
  output logic [DATA_W-1:0]   alu_op1,
  output logic [DATA_W-1:0]   alu_op2,
  output alu_op_t             alu_oper,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                done,
  output logic                done_zero,
  output logic                busy
);

  state_e              state_q, state_d;
  alu_op_t             op_q, op_d;
  logic [ADD_BITS-1:0] rs1_q, rs1_d;
  logic [ADD_BITS-1:0] rs2_q, rs2_d;
  logic [ADD_BITS-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                zero_q, zero_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        // Command fields are only looked at here; later changes are ignored.
        if (cmd_valid) begin
          op_d    = cmd_op;
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
          rd_d    = cmd_rd;
          state_d = RD1;
        end
      end
      RD1: begin
        op1_d   = rf_rd;
        state_d = RD2;
      end
      RD2: begin
        op2_d   = rf_rd;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    rf_ra = '0;
    if (state_q == RD1) rf_ra = rs1_q;
    else if (state_q == RD2) rf_ra = rs2_q;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  // Write strobe decodes straight from state so a reset in WB cannot retract it.
  assign rf_we     = (state_q == WB);
  assign done      = rf_we;
  assign done_zero = done & zero_q;
  assign rf_wa     = rd_q;
  assign rf_wd     = res_q;
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_oper  = op_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural register file and ALU around the DUT,
// a transaction-level model, a per-cycle compare process and directed commands.
module tb_alu_seq_ctrl;
  localparam int AB = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AB-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [AB-1:0] rf_ra, rf_wa;
  logic [DW-1:0] rf_rd, rf_wd;
  logic          rf_we;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [1:0]    alu_oper;
  logic          alu_zero, done, done_zero, busy;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.ADD_BITS(AB), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oper(alu_oper),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .done(done), .done_zero(done_zero), .busy(busy)
  );

  // Register file and ALU stand-ins
  logic [DW-1:0] rf [4];
  logic          pl_en = 1'b0;
  logic [AB-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign rf_rd = rf[rf_ra];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    if (rf_we) rf[rf_wa] <= rf_wd;
  end

  always_comb begin
    case (alu_oper)
      2'd0:    alu_result = alu_op1 + alu_op2;
      2'd1:    alu_result = alu_op1 - alu_op2;
      2'd2:    alu_result = alu_op1 * alu_op2;
      default: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  // Transaction model: a command's result is fixed by the register contents
  // at acceptance; done lands four cycles after the accepting edge.
  function automatic logic [DW-1:0] alu_model(input logic [1:0] op,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] p;
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin p = 64'(a) * 64'(b); return p[31:0]; end
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  logic [DW-1:0] mregs [4];
  int            age = 0;   // 0: idle, else cycles since acceptance
  logic [1:0]    m_op = '0;
  logic [AB-1:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;

  always @(posedge clk) begin
    if (pl_en) mregs[pl_addr] <= pl_data;
    if (age == 4) mregs[m_rd] <= m_res;
    if (reset) age <= 0;
    else if (age == 0) begin
      if (cmd_valid) begin
        age   <= 1;
        m_op  <= cmd_op;
        m_rs1 <= cmd_rs1;
        m_rs2 <= cmd_rs2;
        m_rd  <= cmd_rd;
        m_a   <= mregs[cmd_rs1];
        m_b   <= mregs[cmd_rs2];
        m_res <= alu_model(cmd_op, mregs[cmd_rs1], mregs[cmd_rs2]);
      end
    end else age <= (age == 4) ? 0 : age + 1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic          chk_en = 1'b0;
  int            n_done = 0;
  logic          last_dz = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(age == 0));
      chk("busy",      32'(busy),      32'(age != 0));
      chk("done",      32'(done),      32'(age == 4));
      chk("rf_we",     32'(rf_we),     32'(age == 4));
      chk("rf_ra", 32'(rf_ra), (age == 1) ? 32'(m_rs1) : (age == 2) ? 32'(m_rs2) : 32'd0);
      if (age == 3) begin
        chk("alu_op1",  alu_op1,         m_a);
        chk("alu_op2",  alu_op2,         m_b);
        chk("alu_oper", 32'(alu_oper),   32'(m_op));
      end
      if (age == 4) begin
        chk("rf_wa",     32'(rf_wa),     32'(m_rd));
        chk("rf_wd",     rf_wd,          m_res);
        chk("done_zero", 32'(done_zero), 32'(m_res == 0));
        n_done  <= n_done + 1;
        last_dz <= done_zero;
      end
    end
  end

  task automatic preload(input logic [AB-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #2;
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ready: cmd_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AB-1:0] s1,
                         input logic [AB-1:0] s2, input logic [AB-1:0] d);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = s1; cmd_rs2 = s2; cmd_rd = d;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  int d0;

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst done",      32'(done),      32'd0);
    chk("rst rf_we",     32'(rf_we),     32'd0);
    chk("rst rf_ra",     32'(rf_ra),     32'd0);
    chk("rst rf_wa",     32'(rf_wa),     32'd0);
    chk("rst rf_wd",     rf_wd,          32'd0);
    chk("rst alu_op1",   alu_op1,        32'd0);
    chk("rst alu_op2",   alu_op2,        32'd0);
    chk("rst alu_oper",  32'(alu_oper),  32'd0);
    chk("rst done_zero", 32'(done_zero), 32'd0);
    // cmd_valid during reset must not be accepted
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    chk("rst no accept", 32'(busy), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    preload(0, 32'd0); preload(1, 32'd5); preload(2, 32'd7); preload(3, 32'd0);

    run_cmd(2'd0, 1, 2, 3);
    chk("add r3", rf[3], 32'd12);
    chk("add dz", 32'(last_dz), 32'd0);

    preload(1, 32'd9);
    run_cmd(2'd1, 1, 1, 0);
    chk("sub r0", rf[0], 32'd0);
    chk("sub dz", 32'(last_dz), 32'd1);

    preload(1, 32'hFFFF_FFFF); preload(2, 32'd1);
    run_cmd(2'd3, 1, 2, 2);
    chk("slt r2", rf[2], 32'd1);
    run_cmd(2'd3, 2, 1, 3);
    chk("slt r3", rf[3], 32'd0);
    chk("slt dz", 32'(last_dz), 32'd1);

    // Hold cmd_valid high with fields changing every cycle
    wait_ready();
    d0 = n_done;
    for (int i = 0; i < 11; i++) begin
      cmd_valid = 1'b1;
      cmd_op  = 2'(i);
      cmd_rs1 = 2'(i + 1);
      cmd_rs2 = 2'(i + 2);
      cmd_rd  = 2'(i + 3);
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("overlap dones", 32'(n_done - d0), 32'd3);
    for (int i = 0; i < 4; i++) chk("overlap regs", rf[i], mregs[i]);

    preload(1, 32'd3);
    run_cmd(2'd2, 1, 1, 1);
    chk("mul r1", rf[1], 32'd9);

    // Reset while in EXEC
    preload(0, 32'd10); preload(1, 32'd4); preload(2, 32'h55);
    wait_ready();
    d0 = n_done;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rs1 = 0; cmd_rs2 = 1; cmd_rd = 2;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("mid-rst busy",  32'(busy),      32'd0);
    chk("mid-rst ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(posedge clk);
    #2;
    chk("mid-rst r2",    rf[2],               32'h55);
    chk("mid-rst dones", 32'(n_done - d0),    32'd0);

    run_cmd(2'd0, 0, 1, 2);
    chk("post-rst r2", rf[2], 32'd14);

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
